dspl_digit_fmt: RTL

- Producer side of the 8-digit 7-segment display path.
- Converts a binary value into the eight 6-bit digit codes the display driver consumes: bit5 = digit enable, bits4:1 = hex/BCD nibble, bit0 = decimal point on.
- Decimal mode uses iterative double-dabble, hex mode uses direct nibble slicing.
- Adds leading-zero blanking and decimal-point placement.
- Outputs are registered and update atomically, so the display never shows a half-converted value.

---
 rtl/dspl_pkg.sv | 25 ++
 rtl/dspl_digit_fmt.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dspl_pkg.sv
// Shared definitions for the 7-segment digit formatter: digit-code field
// layout, FSM state encoding and the double-dabble add-3 correction.
package dspl_pkg;

   localparam int EN_BIT  = 5;
   localparam int NIB_MSB = 4;
   localparam int NIB_LSB = 1;
   localparam int DP_BIT  = 0;

   // Largest value eight decimal digits can show.
   localparam logic [31:0] MAX_DEC_DEF = 32'd99999999;

   localparam logic [5:0] BLANK_CODE = 6'b000000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FORMAT = 2'd2
   } state_t;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/dspl_digit_fmt.sv
// Converts a binary value into eight 6-bit display digit codes (decimal via
// iterative double-dabble, hex via nibble slicing) with blanking and dp.
module dspl_digit_fmt
   import dspl_pkg::*;
#(
   parameter int          W       = 27,
   parameter logic [31:0] MAX_DEC = MAX_DEC_DEF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         hex_mode,
   input  logic [W-1:0] value,
   input  logic         blank_en,
   input  logic         dp_en,
   input  logic [2:0]   dp_pos,
   output logic         busy,
   output logic         done,
   output logic         ovf,
   output logic [5:0]   d1,
   output logic [5:0]   d2,
   output logic [5:0]   d3,
   output logic [5:0]   d4,
   output logic [5:0]   d5,
   output logic [5:0]   d6,
   output logic [5:0]   d7,
   output logic [5:0]   d8
);

   function automatic logic over_max(input logic [W-1:0] v);
      return 64'(v) > 64'(MAX_DEC);
   endfunction

   function automatic logic [W-1:0] sat_dec(input logic [W-1:0] v);
      return over_max(v) ? MAX_DEC[W-1:0] : v;
   endfunction

   state_t       state, state_nxt;
   logic [W-1:0] bin_r;
   logic [31:0]  bcd_r;
   logic [31:0]  bcd_adj;
   logic [31:0]  val_ext;
   logic [5:0]   cnt_r;
   logic         hex_r, blank_r, dpen_r, sat_r;
   logic [2:0]   dppos_r;
   logic [5:0]   dig_r [8];
   logic [5:0]   code  [8];
   logic [3:0]   nib;
   logic         run_zero;
   logic         en;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = hex_mode ? FORMAT : SHIFT;
         SHIFT:   if (cnt_r == 6'd1) state_nxt = FORMAT;
         FORMAT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_comb begin
      for (int k = 0; k < 8; k++) bcd_adj[4*k +: 4] = add3(bcd_r[4*k +: 4]);
   end

   // Digit codes are built combinationally from the held operands and only
   // copied into dig_r on the FORMAT edge, so all eight change together.
   always_comb begin
      val_ext          = '0;
      val_ext[W-1:0]   = bin_r;
      run_zero         = 1'b1;
      nib              = 4'd0;
      en               = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         nib      = hex_r ? val_ext[4*k +: 4] : bcd_r[4*k +: 4];
         run_zero = run_zero & (nib == 4'd0);
         en       = ~blank_r | (k == 0) | ~run_zero | (dpen_r & (3'(k) <= dppos_r));
         code[k]  = BLANK_CODE;
         if (en) begin
            code[k][EN_BIT]          = 1'b1;
            code[k][NIB_MSB:NIB_LSB] = nib;
            code[k][DP_BIT]          = dpen_r & (3'(k) == dppos_r);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bin_r   <= '0;
         bcd_r   <= '0;
         cnt_r   <= '0;
         hex_r   <= 1'b0;
         blank_r <= 1'b0;
         dpen_r  <= 1'b0;
         dppos_r <= 3'd0;
         sat_r   <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         for (int k = 0; k < 8; k++) dig_r[k] <= BLANK_CODE;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (start) begin
               hex_r   <= hex_mode;
               blank_r <= blank_en;
               dpen_r  <= dp_en;
               dppos_r <= dp_pos;
               bcd_r   <= '0;
               cnt_r   <= 6'(W);
               if (hex_mode) begin
                  bin_r <= value;
                  sat_r <= 1'b0;
               end else begin
                  bin_r <= sat_dec(value);
                  sat_r <= over_max(value);
               end
            end
            SHIFT: begin
               {bcd_r, bin_r} <= {bcd_adj, bin_r} << 1;
               cnt_r          <= cnt_r - 6'd1;
            end
            FORMAT: begin
               for (int k = 0; k < 8; k++) dig_r[k] <= code[k];
               done <= 1'b1;
               ovf  <= sat_r & ~hex_r;
            end
            default: ;
         endcase
      end
   end

   assign d1 = dig_r[0];
   assign d2 = dig_r[1];
   assign d3 = dig_r[2];
   assign d4 = dig_r[3];
   assign d5 = dig_r[4];
   assign d6 = dig_r[5];
   assign d7 = dig_r[6];
   assign d8 = dig_r[7];

endmodule
